microcode_sequencer: RTL
========================

Name: microcode_sequencer

Overview:
- Parametrised, single-block replacement for the cascaded Am2909/Am2909/Am2911 microsequencer slices in the CPU core.
- Generates the microcode ROM address each cycle from:
  - a 4-bit next-address opcode,
  - a selectable and invertible condition,
  - a configurable-depth subroutine stack,
  - an address register, a mapping-ROM input and a loop counter.
- Adds behaviour the discrete slices lack: stack overflow/underflow detection, a hardware loop counter, an N-way condition mux and a hold/stall.

Parameters:
- ADDR_WIDTH, 11, microcode address width (minimum 5).
- STACK_DEPTH, 4, subroutine stack entries (minimum 1).
- COND_WIDTH, 8, number of condition inputs (minimum 2).
- CTR_WIDTH, 8, loop counter width (≤ ADDR_WIDTH).
- RESET_VECTOR, 0, microcode address presented during and after reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- op  in  4  next-address opcode from the pipeline register
- d_in  in  ADDR_WIDTH  branch target / constant field from the pipeline
- map_in  in  ADDR_WIDTH  mapping-ROM address (opcode dispatch)
- r_in  in  ADDR_WIDTH  address-register load data (F bus)
- ld_ar  in  1  load the address register from r_in
- case_in  in  4  OR-ed into the low nibble for CASE
- cond  in  COND_WIDTH  condition inputs (flags, register_index bit, etc.)
- cond_sel  in  clog2(COND_WIDTH)  selects the condition
- cond_pol  in  1  1 = invert the selected condition
- hold  in  1  stall: re-present the current address, freeze all state
- clr_err  in  1  synchronous clear of the sticky error flags
- uaddr  out  ADDR_WIDTH  microcode ROM address (combinational)
- stack_ptr  out  clog2(STACK_DEPTH+1)  number of occupied stack entries
- stack_empty, stack_full  out  1 each  stack status
- stack_ovf, stack_unf  out  1 each  sticky error flags
- ctr_zero  out  1  loop counter == 0

Behaviour:
- State registers:
  - last_addr: the uaddr presented in the previous cycle.
  - upc = last_addr+1, combinational, modulo 2^ADDR_WIDTH.
  - ar, ctr, stack[STACK_DEPTH], sp, ovf, unf.
- Reset (reset=0, async):
  - uaddr=RESET_VECTOR combinationally; last_addr=RESET_VECTOR; ar=0; ctr=0; sp=0; ovf=unf=0; stack contents don't-care.
  - First address after release under CONT is RESET_VECTOR+1.
- Condition: T = cond[cond_sel] XOR cond_pol. A cond_sel ≥ COND_WIDTH gives T=0 before polarity.
- Opcodes (uaddr shown; every state update happens at the clock edge; last_addr<=uaddr unless hold):
  - 0 CONT: upc.
  - 1 JMP: T ? d_in : upc.
  - 2 JSR: if T, push upc and output d_in; else upc.
  - 3 RTS: if T and !empty, output top and pop; if T and empty, output upc and set unf; else upc.
  - 4 JMAP: map_in, unconditional.
  - 5 JREG: ar, the value before any same-cycle ld_ar.
  - 6 CASE: {d_in[ADDR_WIDTH-1:4], d_in[3:0] | case_in}.
  - 7 LDCT: output upc; ctr<=d_in[CTR_WIDTH-1:0].
  - 8 LOOP: if ctr≠0, output d_in and ctr<=ctr-1; else upc, ctr stays 0.
  - 9 PUSH: output upc; push upc.
  - 10 POP: output upc; discard top (on empty, set unf, sp stays 0).
  - 11-15: behave as CONT.
- Push when full: entry discarded, sp unchanged, ovf set, branch still taken.
- Push/pop are single-cycle; the stack is LIFO; top = stack[sp-1].
- ld_ar is independent of op: ar<=r_in at the edge. It is suppressed by hold.
- hold=1:
  - uaddr=last_addr.
  - No register changes, except clr_err and async reset still act.
- clr_err clears ovf/unf. Set and clear in the same cycle: set wins.
- Status outputs are derived from registers only (no combinational path from op):
  - stack_empty = (sp==0); stack_full = (sp==STACK_DEPTH); ctr_zero = (ctr==0).
- Reset mid-operation (e.g. mid-loop or mid-subroutine) abandons all state. No pending push/pop completes.
- Combinational path: op/cond/d_in/map_in/case_in/hold → uaddr, with no loop through uaddr. The CPU pipeline register latches ROM data.

Test Plan:
- Reset low then release, op=CONT ×3 → uaddr 0x000 during reset, then 0x001, 0x002, 0x003; all flags 0, stack_empty=1.
- At uaddr=0x010: JSR d_in=0x120 with T=1, then CONT, then RTS T=1 → uaddr 0x120, 0x121, 0x011; sp goes 1→1→0.
- Five JSRs with STACK_DEPTH=4 → stack_ovf=1 after the 5th, sp=4. Then 5 RTS → returns in LIFO order; the 5th gives upc and stack_unf=1. clr_err → both flags 0.
- LDCT d_in=3 at 0x040, then LOOP d_in=0x040 repeatedly → branches taken 3 times (ctr 3→2→1→0), 4th LOOP falls through to 0x041, ctr_zero=1.
- JMP d_in=0x200 with cond[2]=1, cond_sel=2: cond_pol=0 → 0x200; cond_pol=1 → upc. CASE d_in=0x130, case_in=0x5 → 0x135. uaddr=0x7FF then CONT → 0x000 (wrap).
- hold=1 for 2 cycles during JSR → uaddr stays at the previous value, sp unchanged. ld_ar with r_in=0x3AA in the same cycle as JREG → old ar output; next JREG → 0x3AA.

Source files
------------

// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//   Single-block microprogram sequencer. Each cycle it produces the microcode
//   ROM address from a 4-bit next-address opcode, a selectable/invertible
//   condition, a LIFO subroutine stack, an address register, a mapping-ROM
//   input and a hardware loop counter. Stack overflow/underflow are sticky
//   error flags. A hold input stalls the sequencer.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   op           next-address opcode
//   d_in         branch target / constant field
//   map_in       mapping-ROM dispatch address
//   r_in         address-register load data
//   ld_ar        load address register from r_in
//   case_in      OR-ed into the low nibble for CASE
//   cond         condition inputs
//   cond_sel     condition select
//   cond_pol     1 = invert the selected condition
//   hold         stall: re-present current address, freeze state
//   clr_err      synchronous clear of stack_ovf/stack_unf
//   uaddr        microcode ROM address (combinational)
//   stack_ptr    number of occupied stack entries
//   stack_empty  stack_ptr == 0
//   stack_full   stack_ptr == STACK_DEPTH
//   stack_ovf    sticky push-while-full flag
//   stack_unf    sticky pop-while-empty flag
//   ctr_zero     loop counter == 0
// -----------------------------------------------------------------------------
module microcode_sequencer #(
    parameter int                    ADDR_WIDTH   = 11,
    parameter int                    STACK_DEPTH  = 4,
    parameter int                    COND_WIDTH   = 8,
    parameter int                    CTR_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [3:0]                     op,
    input  logic [ADDR_WIDTH-1:0]          d_in,
    input  logic [ADDR_WIDTH-1:0]          map_in,
    input  logic [ADDR_WIDTH-1:0]          r_in,
    input  logic                           ld_ar,
    input  logic [3:0]                     case_in,
    input  logic [COND_WIDTH-1:0]          cond,
    input  logic [$clog2(COND_WIDTH)-1:0]  cond_sel,
    input  logic                           cond_pol,
    input  logic                           hold,
    input  logic                           clr_err,
    output logic [ADDR_WIDTH-1:0]          uaddr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_ptr,
    output logic                           stack_empty,
    output logic                           stack_full,
    output logic                           stack_ovf,
    output logic                           stack_unf,
    output logic                           ctr_zero
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [3:0] OP_CONT = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_JSR  = 4'd2;
    localparam logic [3:0] OP_RTS  = 4'd3;
    localparam logic [3:0] OP_JMAP = 4'd4;
    localparam logic [3:0] OP_JREG = 4'd5;
    localparam logic [3:0] OP_CASE = 4'd6;
    localparam logic [3:0] OP_LDCT = 4'd7;
    localparam logic [3:0] OP_LOOP = 4'd8;
    localparam logic [3:0] OP_PUSH = 4'd9;
    localparam logic [3:0] OP_POP  = 4'd10;

    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] ar;
    logic [CTR_WIDTH-1:0]  ctr;
    logic [SP_W-1:0]       sp;
    logic                  ovf;
    logic                  unf;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] upc;
    logic [ADDR_WIDTH-1:0] top;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  t_raw;
    logic                  cond_t;
    logic                  push_req;
    logic                  pop_req;
    logic                  set_ovf;
    logic                  set_unf;
    logic                  ctr_load;
    logic                  ctr_dec;
    logic                  sp_empty;
    logic                  sp_full;

    assign upc      = last_addr + ADDR_WIDTH'(1);
    assign sp_empty = (sp == '0);
    assign sp_full  = (sp == SP_W'(STACK_DEPTH));
    assign cond_t   = t_raw ^ cond_pol;
    assign set_ovf  = push_req & sp_full;

    always_comb begin
        // Out-of-range selects (non-power-of-two COND_WIDTH) read as 0.
        t_raw = 1'b0;
        for (int unsigned i = 0; i < COND_WIDTH; i++) begin
            if (32'(cond_sel) == i) t_raw = cond[i];
        end

        top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (32'(sp) == i + 1) top = stack_mem[i];
        end

        next_addr = upc;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        set_unf   = 1'b0;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;

        case (op)
            OP_JMP:  if (cond_t) next_addr = d_in;
            OP_JSR: begin
                if (cond_t) begin
                    next_addr = d_in;
                    push_req  = 1'b1;
                end
            end
            OP_RTS: begin
                if (cond_t) begin
                    if (sp_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        next_addr = top;
                        pop_req   = 1'b1;
                    end
                end
            end
            OP_JMAP: next_addr = map_in;
            OP_JREG: next_addr = ar;
            OP_CASE: next_addr = {d_in[ADDR_WIDTH-1:4], d_in[3:0] | case_in};
            OP_LDCT: ctr_load = 1'b1;
            OP_LOOP: begin
                if (ctr != '0) begin
                    next_addr = d_in;
                    ctr_dec   = 1'b1;
                end
            end
            OP_PUSH: push_req = 1'b1;
            OP_POP: begin
                if (sp_empty) set_unf = 1'b1;
                else          pop_req = 1'b1;
            end
            default: next_addr = upc;
        endcase

        if (!reset)    uaddr = RESET_VECTOR;
        else if (hold) uaddr = last_addr;
        else           uaddr = next_addr;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_addr <= RESET_VECTOR;
            ar        <= '0;
            ctr       <= '0;
            sp        <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            if (!hold) begin
                last_addr <= next_addr;
                if (ld_ar) ar <= r_in;
                if (ctr_load)     ctr <= d_in[CTR_WIDTH-1:0];
                else if (ctr_dec) ctr <= ctr - CTR_WIDTH'(1);
                if (push_req && !sp_full) sp <= sp + SP_W'(1);
                else if (pop_req)         sp <= sp - SP_W'(1);
            end
            // A set in the same cycle as clr_err wins.
            ovf <= (set_ovf & ~hold) | (ovf & ~clr_err);
            unf <= (set_unf & ~hold) | (unf & ~clr_err);
        end
    end

    // Stack storage carries no reset; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (reset && !hold && push_req && !sp_full) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                if (32'(sp) == i) stack_mem[i] <= upc;
            end
        end
    end

    assign stack_ptr   = sp;
    assign stack_empty = sp_empty;
    assign stack_full  = sp_full;
    assign stack_ovf   = ovf;
    assign stack_unf   = unf;
    assign ctr_zero    = (ctr == '0);

endmodule
